// File: rtl/sram_like_bridge.sv
// Bridges a single-cycle CPU SRAM port onto a variable-latency sram-like port.
// Generates the per-channel stall, honours global stall/flush and counts stall cycles.
module sram_like_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cpu_en,
    input  logic [DATA_W/8-1:0] cpu_wen,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_stall,
    input  logic                longest_stall,
    input  logic                flush,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [1:0]          mem_size,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [CNT_W-1:0]    stall_cycles
);

    localparam int BYTES = DATA_W / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] FULL_SIZE = (DATA_W == 64) ? 2'd3 : 2'd2;

    logic [1:0] state_reg;
    logic       discard_reg;
    logic [1:0] size_next;
    logic [3:0] wen_count [0:BYTES];

    // Running popcount of the byte enables.
    assign wen_count[0] = 4'd0;
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_popcount
            assign wen_count[gi+1] = wen_count[gi] + {3'b000, cpu_wen[gi]};
        end
    endgenerate

    // Only the exact power-of-two patterns map to a narrow size; everything
    // else, reads included, is a full-width access.
    always_comb begin
        size_next = FULL_SIZE;
        case (wen_count[BYTES])
            4'd1:    size_next = 2'd0;
            4'd2:    size_next = 2'd1;
            4'd4:    size_next = 2'd2;
            4'd8:    size_next = 2'd3;
            default: size_next = FULL_SIZE;
        endcase
    end

    always_comb begin
        cpu_stall = 1'b0;
        if (resetn) begin
            case (state_reg)
                IDLE:    cpu_stall = cpu_en & ~flush;
                REQ:     cpu_stall = 1'b1;
                WAIT:    cpu_stall = 1'b1;
                default: cpu_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            discard_reg  <= 1'b0;
            mem_req      <= 1'b0;
            mem_wr       <= 1'b0;
            mem_size     <= 2'd0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_rdata    <= '0;
            stall_cycles <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cpu_en && !flush) begin
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        mem_wr    <= |cpu_wen;
                        mem_size  <= size_next;
                        mem_req   <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    // The request must stay up until accepted, so a flush only
                    // marks the eventual response for discard.
                    if (flush) begin
                        discard_reg <= 1'b1;
                    end
                    if (mem_addr_ok) begin
                        mem_req   <= 1'b0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_data_ok) begin
                        if (!mem_wr && !discard_reg && !flush) begin
                            cpu_rdata <= mem_rdata;
                        end
                        discard_reg <= 1'b0;
                        state_reg   <= (discard_reg || flush) ? IDLE : DONE;
                    end else if (flush) begin
                        discard_reg <= 1'b1;
                    end
                end
                default: begin
                    if (flush || !longest_stall) begin
                        state_reg <= IDLE;
                    end
                end
            endcase

            if (cpu_stall && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge: read, byte store, global-stall hold,
// flush discard, reset mid-request and counter saturation (CNT_W=4 copy).
module tb_sram_like_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        longest_stall;
    logic        flush;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] stall_cycles;

    logic [31:0] s_cpu_rdata;
    logic        s_cpu_stall;
    logic        s_mem_req;
    logic        s_mem_wr;
    logic [1:0]  s_mem_size;
    logic [31:0] s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [3:0]  s_stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sram_like_bridge dut (
        .clk(clk), .resetn(resetn),
        .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .longest_stall(longest_stall), .flush(flush),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .stall_cycles(stall_cycles)
    );

    sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut_sat (
        .clk(clk), .resetn(resetn),
        .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
        .longest_stall(longest_stall), .flush(flush),
        .mem_req(s_mem_req), .mem_wr(s_mem_wr), .mem_size(s_mem_size), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .stall_cycles(s_stall_cycles)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; cpu_en = 1'b0; cpu_wen = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        longest_stall = 1'b0; flush = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        mem_rdata = 32'h0;

        // Reset state; stall forced low even with a request pending
        tick(); tick();
        cpu_en = 1'b1; #1;
        chk("rst_stall", 64'(cpu_stall), 64'h0);
        chk("rst_req", 64'(mem_req), 64'h0);
        chk("rst_addr", 64'(mem_addr), 64'h0);
        chk("rst_rdata", 64'(cpu_rdata), 64'h0);
        chk("rst_cnt", 64'(stall_cycles), 64'h0);
        cpu_en = 1'b0;
        tick();
        resetn = 1'b1; #1;

        // Read 0xBFC00000: addr_ok first REQ cycle, data_ok two cycles later
        cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'hBFC0_0000; #1;
        chk("rd_idle_stall", 64'(cpu_stall), 64'h1);
        tick(); cpu_en = 1'b0; #1;
        chk("rd_req", 64'(mem_req), 64'h1);
        chk("rd_wr", 64'(mem_wr), 64'h0);
        chk("rd_size", 64'(mem_size), 64'h2);
        chk("rd_addr", 64'(mem_addr), 64'hBFC0_0000);
        mem_addr_ok = 1'b1;
        tick(); mem_addr_ok = 1'b0; #1;
        chk("rd_req_drop", 64'(mem_req), 64'h0);
        chk("rd_wait_stall", 64'(cpu_stall), 64'h1);
        tick(); mem_data_ok = 1'b1; mem_rdata = 32'h3C1D_8000; #1;
        chk("rd_wait_stall2", 64'(cpu_stall), 64'h1);
        tick(); mem_data_ok = 1'b0; mem_rdata = 32'h0; #1;
        chk("rd_done_stall", 64'(cpu_stall), 64'h0);
        chk("rd_data", 64'(cpu_rdata), 64'h3C1D_8000);
        chk("rd_cnt", 64'(stall_cycles), 64'd4);
        tick(); #1;
        chk("rd_idle_cnt", 64'(stall_cycles), 64'd4);

        // Byte store: addr_ok delayed one cycle, write response ignores rdata
        cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_addr = 32'h8000_0002; cpu_wdata = 32'h00AB_0000; #1;
        chk("sb_idle_stall", 64'(cpu_stall), 64'h1);
        tick(); cpu_en = 1'b0; cpu_wen = 4'h0; #1;
        chk("sb_req", 64'(mem_req), 64'h1);
        chk("sb_wr", 64'(mem_wr), 64'h1);
        chk("sb_size", 64'(mem_size), 64'h0);
        chk("sb_addr", 64'(mem_addr), 64'h8000_0002);
        chk("sb_wdata", 64'(mem_wdata), 64'h00AB_0000);
        tick();
        chk("sb_req_hold", 64'(mem_req), 64'h1);
        chk("sb_addr_hold", 64'(mem_addr), 64'h8000_0002);
        mem_addr_ok = 1'b1;
        tick(); mem_addr_ok = 1'b0; #1;
        chk("sb_req_drop", 64'(mem_req), 64'h0);
        chk("sb_wait_stall", 64'(cpu_stall), 64'h1);
        tick(); mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
        chk("sb_wait_stall2", 64'(cpu_stall), 64'h1);
        tick(); mem_data_ok = 1'b0; mem_rdata = 32'h0; #1;
        chk("sb_done_stall", 64'(cpu_stall), 64'h0);
        chk("sb_rdata_kept", 64'(cpu_rdata), 64'h3C1D_8000);
        chk("sb_cnt", 64'(stall_cycles), 64'd9);
        tick();

        // Global stall hold in DONE with a new cpu_en presented
        cpu_en = 1'b1; cpu_addr = 32'h0000_0100; #1;
        tick(); cpu_en = 1'b0; mem_addr_ok = 1'b1;
        tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678; longest_stall = 1'b1;
        tick(); mem_data_ok = 1'b0; mem_rdata = 32'h0; cpu_en = 1'b1; cpu_addr = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("gs_stall", 64'(cpu_stall), 64'h0);
            chk("gs_rdata", 64'(cpu_rdata), 64'h1234_5678);
            chk("gs_no_req", 64'(mem_req), 64'h0);
            tick();
        end
        longest_stall = 1'b0; cpu_en = 1'b0; #1;
        tick();
        chk("gs_idle_req", 64'(mem_req), 64'h0);
        chk("gs_cnt", 64'(stall_cycles), 64'd12);

        // Flush during WAIT: response consumed, not delivered
        cpu_en = 1'b1; cpu_addr = 32'h0000_0300; #1;
        chk("fl_idle_stall", 64'(cpu_stall), 64'h1);
        tick(); cpu_en = 1'b0; mem_addr_ok = 1'b1;
        tick(); mem_addr_ok = 1'b0; flush = 1'b1; #1;
        chk("fl_wait_stall", 64'(cpu_stall), 64'h1);
        tick(); flush = 1'b0; #1;
        chk("fl_wait_stall2", 64'(cpu_stall), 64'h1);
        tick(); mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick(); mem_data_ok = 1'b0; mem_rdata = 32'h0; #1;
        chk("fl_rdata_kept", 64'(cpu_rdata), 64'h1234_5678);
        chk("fl_stall_low", 64'(cpu_stall), 64'h0);
        cpu_en = 1'b1; #1;
        chk("fl_back_idle", 64'(cpu_stall), 64'h1);
        flush = 1'b1; #1;
        chk("fl_idle_flush_stall", 64'(cpu_stall), 64'h0);
        tick(); flush = 1'b0; cpu_en = 1'b0; #1;
        chk("fl_idle_flush_req", 64'(mem_req), 64'h0);
        chk("fl_cnt", 64'(stall_cycles), 64'd17);

        // Reset in the middle of REQ
        cpu_en = 1'b1; cpu_wen = 4'b1111; cpu_addr = 32'h0000_0400; cpu_wdata = 32'h5555_5555; #1;
        tick(); #1;
        chk("rq_req", 64'(mem_req), 64'h1);
        chk("rq_size", 64'(mem_size), 64'h2);
        chk("rq_cnt", 64'(stall_cycles), 64'd18);
        #2 resetn = 1'b0; #1;
        chk("rq_rst_req", 64'(mem_req), 64'h0);
        chk("rq_rst_stall", 64'(cpu_stall), 64'h0);
        chk("rq_rst_wr", 64'(mem_wr), 64'h0);
        chk("rq_rst_size", 64'(mem_size), 64'h0);
        chk("rq_rst_addr", 64'(mem_addr), 64'h0);
        chk("rq_rst_wdata", 64'(mem_wdata), 64'h0);
        chk("rq_rst_rdata", 64'(cpu_rdata), 64'h0);
        chk("rq_rst_cnt", 64'(stall_cycles), 64'h0);
        chk("rq_rst_cnt_sat", 64'(s_stall_cycles), 64'h0);
        cpu_en = 1'b0; cpu_wen = 4'h0;
        tick();
        resetn = 1'b1; #1;

        // Halfword store with a 20-cycle stall; 4-bit counter saturates at 15
        cpu_en = 1'b1; cpu_wen = 4'b0011; cpu_addr = 32'h0000_0500; cpu_wdata = 32'h0000_BEEF; #1;
        tick(); cpu_en = 1'b0; cpu_wen = 4'h0; #1;
        chk("sh_size", 64'(mem_size), 64'h1);
        chk("sh_wr", 64'(mem_wr), 64'h1);
        repeat (10) tick();
        mem_addr_ok = 1'b1;
        tick(); mem_addr_ok = 1'b0;
        repeat (7) tick();
        mem_data_ok = 1'b1;
        tick(); mem_data_ok = 1'b0; #1;
        chk("sat_done_stall", 64'(cpu_stall), 64'h0);
        chk("sat_rdata", 64'(cpu_rdata), 64'h0);
        chk("sat_cnt_wide", 64'(stall_cycles), 64'd20);
        chk("sat_cnt_4b", 64'(s_stall_cycles), 64'd15);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_like_bridge.md
Name: sram_like_bridge

Overview:
- Single-channel bridge between the pipeline's single-cycle SRAM port (en/wen/addr/wdata/rdata) and a variable-latency sram-like memory port (req/addr_ok/data_ok).
- Produces the per-channel stall that the CPU top currently ties to 0.
- Instantiated twice in the next CPU top: once for instruction fetch, once for data.
- Parametrised in address/data width. Adds behaviour the current top lacks: transfer-size derivation, global-stall hold, flush with response discard, and a stall-cycle performance counter.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; legal values are 32 or 64.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cpu_en  in  1  CPU access request for this cycle.
- cpu_wen  in  DATA_W/8  byte write enables; all zero means read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data; valid while state is DONE.
- cpu_stall  out  1  stall request to the pipeline.
- longest_stall  in  1  global pipeline stall (OR of all stall sources).
- flush  in  1  exception flush; the current access is abandoned.
- mem_req  out  1  sram-like request.
- mem_wr  out  1  1 = write.
- mem_size  out  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_W  write data.
- mem_addr_ok  in  1  request accepted.
- mem_data_ok  in  1  response / write complete.
- mem_rdata  in  DATA_W  read response data.
- stall_cycles  out  CNT_W  saturating count of cycles with cpu_stall=1.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, discard=0.
  - mem_req, mem_wr, mem_size, mem_addr, mem_wdata, cpu_rdata, stall_cycles all 0.
  - cpu_stall forced 0 while resetn=0.
  - Reset mid-transaction drops everything. No response is awaited after release; the memory side is reset by the same resetn.
- State IDLE:
  - cpu_stall = cpu_en & ~flush.
  - On cpu_en & ~flush: latch mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_wr=|cpu_wen, mem_size; go to REQ.
- mem_size derivation:
  - Popcount of cpu_wen: 1→0, 2→1, 4→2, 8→3.
  - Reads (wen=0) and any other popcount → full width (2 for DATA_W=32, 3 for DATA_W=64).
- State REQ:
  - mem_req=1 (registered, first asserted the cycle after cpu_en is seen); cpu_stall=1.
  - Request fields stay stable until mem_addr_ok.
  - On mem_addr_ok: mem_req←0, go to WAIT.
  - mem_req is never withdrawn before mem_addr_ok, even on flush.
- State WAIT:
  - cpu_stall=1.
  - On mem_data_ok: cpu_rdata←mem_rdata for reads; cpu_rdata unchanged for writes.
  - Next state: IDLE if discard, else DONE.
  - Clear discard on mem_data_ok.
  - mem_data_ok arriving in the same cycle as mem_addr_ok (while in REQ) is not supported; the memory guarantees at least one cycle between them.
- State DONE:
  - cpu_stall=0; cpu_rdata held.
  - If longest_stall=0: go to IDLE (the pipeline consumes the data this cycle).
  - If longest_stall=1: stay in DONE, keep data, issue no new request.
- Flush:
  - In REQ or WAIT: set discard=1. The response is still consumed but not delivered; the state does not enter DONE.
  - In DONE: go to IDLE.
  - In IDLE: no request is started that cycle.
  - Flush overrides longest_stall.
- Latency: minimum CPU stall for one access is 3 cycles (IDLE-detect, REQ with addr_ok, WAIT with data_ok), then DONE.
- Counter:
  - stall_cycles increments each cycle cpu_stall=1.
  - Saturates at all-ones; does not wrap.
- Only one transaction is outstanding at a time.

Test Plan:
- Read, DATA_W=32: cpu_en=1, wen=0, addr=0xBFC00000; addr_ok on first REQ cycle, data_ok 2 cycles later with 0x3C1D8000 → mem_size=2, mem_wr=0, cpu_stall high 4 cycles, then cpu_rdata=0x3C1D8000 with stall=0; stall_cycles=4.
- Byte store: wen=4'b0100, addr=0x80000002, wdata=0x00AB0000 → mem_req=1, mem_wr=1, mem_size=0, mem_addr=0x80000002; stall drops only after data_ok.
- Global stall hold: read completes with 0x12345678 while longest_stall=1 for 3 cycles → DONE held, cpu_stall=0, cpu_rdata=0x12345678 stable, mem_req stays 0; returns to IDLE when longest_stall falls.
- Flush in WAIT: flush pulse during WAIT, data_ok later with 0xDEADBEEF → cpu_rdata keeps its previous value, state returns to IDLE, next cpu_en starts a fresh REQ.
- Reset mid-REQ: resetn low while mem_req=1 → mem_req=0 immediately, all outputs 0, stall_cycles=0.
- Saturation: CNT_W=4 with a 20-cycle stall → stall_cycles stops at 15.
